digit_entry: RTL and testbench

DIGIT_ENTRY -- requirements
Module: digit_entry

---
 rtl/digit_entry.sv | 158 +++++++++++++++
 tb/tb_digit_entry.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_entry.sv
// Six-digit BCD entry controller: debounced ENTER/MODE keys, a cursor, and abort/restore.
// Optional cursor blink is enabled by defining DIGIT_ENTRY_BLINK_EN.
module digit_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BLINK_CYCLES    = 12500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  switch,
  input  logic [1:0]  key,
  output logic [23:0] digits,
  output logic [2:0]  cursor,
  output logic        valid,
  output logic        err,
  output logic [5:0]  blank
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;

  generate
    if (DEBOUNCE_CYCLES < 2 || BLINK_CYCLES < 2) begin : g_param_check
      $error("digit_entry: DEBOUNCE_CYCLES and BLINK_CYCLES must be at least 2");
    end
  endgenerate

  logic [1:0]    sync1_q, sync2_q, deb_q, deb_prev_q, arm_q, pipe_q;
  logic [DW-1:0] cnt_q [2];
  logic [1:0]    press_c;
  logic          enter_c, mode_c;
  logic [5:0]    unused_sw;

  state_t        state_q;
  logic [23:0]   digits_q, shadow_q;
  logic [2:0]    cursor_q;
  logic          valid_q, err_q;

  assign unused_sw = switch[9:4];

  // Synchronize and debounce both keys; arm_q blocks events until a key is seen released after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      deb_prev_q <= '1;
      arm_q      <= '0;
      pipe_q     <= '0;
      for (int k = 0; k < 2; k++) cnt_q[k] <= '0;
    end else begin
      sync1_q    <= key;
      sync2_q    <= sync1_q;
      pipe_q     <= {pipe_q[0], 1'b1};
      deb_prev_q <= deb_q;
      arm_q      <= arm_q | ({2{pipe_q[1]}} & sync2_q & deb_q);
      for (int k = 0; k < 2; k++) begin
        if (sync2_q[k] != deb_q[k]) begin
          if (cnt_q[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb_q[k] <= sync2_q[k];
            cnt_q[k] <= '0;
          end else begin
            cnt_q[k] <= cnt_q[k] + DW'(1);
          end
        end else begin
          cnt_q[k] <= '0;
        end
      end
    end
  end

  assign press_c = deb_prev_q & ~deb_q & arm_q;
  assign mode_c  = press_c[1];
  assign enter_c = press_c[0] & ~press_c[1];

`ifdef DIGIT_ENTRY_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_CYCLES);
  logic [BW-1:0] blink_cnt_q;
  logic          phase_q;
`endif

  // Entry FSM; MODE wins over a simultaneous ENTER
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      digits_q <= '0;
      shadow_q <= '0;
      cursor_q <= 3'd5;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef DIGIT_ENTRY_BLINK_EN
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
`ifdef DIGIT_ENTRY_BLINK_EN
      if (state_q == ENTRY) begin
        if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
          blink_cnt_q <= '0;
          phase_q     <= ~phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
      end else begin
        blink_cnt_q <= '0;
        phase_q     <= 1'b0;
      end
`endif
      case (state_q)
        ENTRY: begin
          if (mode_c) begin
            digits_q <= shadow_q;
            valid_q  <= 1'b0;
            cursor_q <= 3'd5;
            state_q  <= IDLE;
          end else if (enter_c) begin
            if (switch[3:0] <= 4'd9) begin
              for (int i = 0; i < 6; i++)
                if (cursor_q == 3'(i)) digits_q[4*i +: 4] <= switch[3:0];
              if (cursor_q != 3'd0) begin
                cursor_q <= cursor_q - 3'd1;
              end else begin
                valid_q <= 1'b1;
                state_q <= DONE;
              end
`ifdef DIGIT_ENTRY_BLINK_EN
              blink_cnt_q <= '0;
              phase_q     <= 1'b0;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          if (mode_c) begin
            shadow_q <= digits_q;
            cursor_q <= 3'd5;
            valid_q  <= 1'b0;
            state_q  <= ENTRY;
          end
        end
      endcase
    end
  end

  assign digits = digits_q;
  assign cursor = cursor_q;
  assign valid  = valid_q;
  assign err    = err_q;
`ifdef DIGIT_ENTRY_BLINK_EN
  assign blank  = phase_q ? 6'(6'b1 << cursor_q) : 6'b0;
`else
  assign blank  = 6'b0;
`endif

endmodule

// File: tb/tb_digit_entry.sv
// Scoreboard bench for digit_entry: a reference model pushes expected results per key press.
module tb_digit_entry;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  switch;
  logic [1:0]  key;
  logic [23:0] digits;
  logic [2:0]  cursor;
  logic        valid, err;
  logic [5:0]  blank;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int blank_nz = 0;

  typedef struct {
    logic [23:0] d;
    logic [2:0]  c;
    logic        v;
    int          e;
  } exp_t;

  exp_t sb[$];

  int          m_state;
  logic [23:0] m_dig, m_shadow;
  int          m_cur;
  logic        m_val;

  digit_entry #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .switch(switch), .key(key),
    .digits(digits), .cursor(cursor), .valid(valid), .err(err), .blank(blank)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (blank !== 6'b0) blank_nz++;
  end

  task automatic model_reset();
    m_state = 0; m_dig = '0; m_shadow = '0; m_cur = 5; m_val = 1'b0;
    sb.delete();
  endtask

  // Reference behaviour of one key event (mask[1]=MODE, mask[0]=ENTER)
  task automatic model_event(input logic [1:0] mask, input logic [3:0] sw);
    exp_t x;
    int   e = 0;
    if (mask[1]) begin
      if (m_state != 1) begin
        m_shadow = m_dig; m_cur = 5; m_val = 1'b0; m_state = 1;
      end else begin
        m_dig = m_shadow; m_cur = 5; m_val = 1'b0; m_state = 0;
      end
    end else if (mask[0] && m_state == 1) begin
      if (sw <= 4'd9) begin
        m_dig[4*m_cur +: 4] = sw;
        if (m_cur > 0) m_cur--;
        else begin m_val = 1'b1; m_state = 2; end
      end else begin
        e = 1;
      end
    end
    x.d = m_dig; x.c = 3'(m_cur); x.v = m_val; x.e = e;
    sb.push_back(x);
  endtask

  task automatic press(input logic [1:0] mask, input logic [3:0] sw, input string name);
    exp_t x;
    int   e0;
    switch = {6'b101010, sw};
    model_event(mask, sw);
    e0 = err_cnt;
    @(negedge clk) key = ~mask;
    repeat (10) @(negedge clk);
    key = 2'b11;
    repeat (10) @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      x = sb.pop_front();
      if (digits !== x.d || cursor !== x.c || valid !== x.v || (err_cnt - e0) != x.e) begin
        errors++;
        $display("FAIL %s: got digits=%h cursor=%0d valid=%b errcycles=%0d, expected digits=%h cursor=%0d valid=%b errcycles=%0d",
                 name, digits, cursor, valid, err_cnt - e0, x.d, x.c, x.v, x.e);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (digits !== 24'h0 || cursor !== 3'd5 || valid !== 1'b0 || err !== 1'b0 || blank !== 6'b0) begin
      errors++;
      $display("FAIL reset_values: got digits=%h cursor=%0d valid=%b err=%b blank=%b, expected 000000 5 0 0 000000",
               digits, cursor, valid, err, blank);
    end
  endtask

  task automatic test_glitch();
    press(2'b10, 4'd0, "glitch_mode_in");
    switch = {6'b0, 4'd5};
    model_event(2'b00, 4'd5);
    @(negedge clk) key = 2'b10;
    repeat (3) @(negedge clk);
    key = 2'b11;
    repeat (15) @(negedge clk);
    begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      if (digits !== x.d || cursor !== x.c) begin
        errors++;
        $display("FAIL glitch_no_event: got digits=%h cursor=%0d, expected digits=%h cursor=%0d",
                 digits, cursor, x.d, x.c);
      end
    end
    press(2'b10, 4'd0, "glitch_mode_out");
  endtask

  task automatic test_full_entry();
    logic [3:0] seq [6];
    seq[0] = 4'd0; seq[1] = 4'd8; seq[2] = 4'd0; seq[3] = 4'd2; seq[4] = 4'd1; seq[5] = 4'd0;
    press(2'b10, 4'd0, "entry_mode");
    for (int i = 0; i < 6; i++) press(2'b01, seq[i], $sformatf("entry_digit%0d", i));
    checks++;
    if (digits !== 24'h080210 || valid !== 1'b1 || cursor !== 3'd0) begin
      errors++;
      $display("FAIL entry_final: got digits=%h valid=%b cursor=%0d, expected 080210 1 0", digits, valid, cursor);
    end
  endtask

  task automatic test_enter_ignored();
    press(2'b01, 4'd5, "done_enter_ignored");
    press(2'b01, 4'hE, "done_nonbcd_no_err");
  endtask

  task automatic test_err_and_abort();
    press(2'b10, 4'd0, "abort_mode_in");
    press(2'b01, 4'd7, "abort_d5");
    press(2'b01, 4'd7, "abort_d4");
    press(2'b01, 4'hC, "nonbcd_err");
    press(2'b10, 4'd0, "abort_restore");
    checks++;
    if (digits !== 24'h080210 || valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_final: got digits=%h valid=%b, expected 080210 0", digits, valid);
    end
    press(2'b01, 4'd3, "idle_enter_ignored");
  endtask

  task automatic test_blink();
    int bad = 0;
    press(2'b10, 4'd0, "blink_mode_in");
    press(2'b01, 4'd1, "blink_d5");
`ifdef DIGIT_ENTRY_BLINK_EN
    begin
      int         last = -1;
      int         trans = 0;
      logic [5:0] prev;
      prev = blank;
      for (int i = 0; i < 48; i++) begin
        @(negedge clk);
        if (blank !== 6'b0 && blank !== 6'b010000) bad++;
        if (blank !== prev) begin
          if (last >= 0 && (i - last) != 8) bad++;
          last = i;
          trans++;
        end
        prev = blank;
      end
      checks++;
      if (bad != 0 || trans < 4) begin
        errors++;
        $display("FAIL blink_pattern: got %0d bad samples and %0d toggles, expected 0 bad and at least 4 toggles", bad, trans);
      end
    end
`else
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (blank !== 6'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL blink_off: got %0d nonzero blank samples, expected 0", bad);
    end
`endif
  endtask

  task automatic test_back_to_back();
    press(2'b11, 4'd6, "simultaneous_abort");
    press(2'b10, 4'd0, "reset_mode_in");
    press(2'b01, 4'd9, "reset_d5");
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (digits !== 24'h0 || cursor !== 3'd5 || valid !== 1'b0 || err !== 1'b0 || blank !== 6'b0) begin
      errors++;
      $display("FAIL async_reset_mid_entry: got digits=%h cursor=%0d valid=%b err=%b blank=%b, expected 000000 5 0 0 000000",
               digits, cursor, valid, err, blank);
    end
  endtask

  task automatic test_held_at_release();
    key = 2'b01;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    key = 2'b11;
    repeat (20) @(negedge clk);
    press(2'b01, 4'd3, "held_release_no_event");
    press(2'b10, 4'd0, "after_held_mode");
    press(2'b01, 4'd4, "after_held_d5");
  endtask

  initial begin
    rst_n = 1'b0; key = 2'b11; switch = '0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    test_reset();
    test_glitch();
    test_full_entry();
    test_enter_ignored();
    test_err_and_abort();
    test_blink();
    test_back_to_back();
    test_held_at_release();
`ifndef DIGIT_ENTRY_BLINK_EN
    checks++;
    if (blank_nz != 0) begin
      errors++;
      $display("FAIL blank_constant: got %0d nonzero samples, expected 0", blank_nz);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
